// File: rtl/result_writer.sv
// result_writer: drains the 24-bit result FIFO and writes each result into SRAM
// through the 16-bit word-addressed arbiter bus, starting at a programmable base.
// Optional feature macro: RESULT_WRITER_PACK_EN packs two results into three
// halfwords instead of spending two halfwords per result.
module result_writer #(
  parameter int          ADDR_WIDTH  = 20,
  parameter int          COUNT_WIDTH = 16,
  parameter logic [15:0] END_MARKER  = 16'hFFFF
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_address,
  input  logic [COUNT_WIDTH-1:0] max_results,
  input  logic                   finish,
  input  logic [23:0]            rfifo_dataq,
  input  logic                   rfifo_rdempty,
  output logic                   rfifo_rdreq,
  output logic [ADDR_WIDTH-1:0]  address,
  output logic [1:0]             byteenable,
  output logic                   write,
  output logic [15:0]            writedata,
  input  logic                   waitrequest,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] result_count,
  output logic                   wrapped
);

  // WR_PART only appears in packed builds; it flushes a half-written pair
  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WR_LO,
    WR_HI,
    WR_END,
    WR_PART,
    DONE
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [ADDR_WIDTH-1:0]  ptr;
  logic [COUNT_WIDTH-1:0] limit;
  logic [COUNT_WIDTH-1:0] count_inc_val;
  logic [23:0]            hold;
  logic                   complete;
  logic                   count_step;
  logic                   limit_hit;

`ifdef RESULT_WRITER_PACK_EN
  logic [23:0] hold_b;
  logic        pending;
  logic        tail;
  logic        marker_due;
`endif

  // a bus write retires only when the arbiter stops stalling it
  assign complete      = write && !waitrequest;
  assign count_inc_val = (&result_count) ? result_count : result_count + COUNT_WIDTH'(1);
  assign limit_hit     = (limit != '0) && (count_inc_val == limit);
  assign address       = ptr;
  assign busy          = (state != IDLE);

  // state register; reset drops any write in flight with no completion
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state decode and bus/FIFO strobes; bus outputs depend only on
  // registered state so they stay stable while waitrequest is high
  always_comb begin
    state_nxt   = state;
    write       = 1'b0;
    byteenable  = 2'b00;
    writedata   = 16'h0000;
    rfifo_rdreq = 1'b0;
    done        = 1'b0;
    count_step  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (!rfifo_rdempty) begin
          rfifo_rdreq = 1'b1;
`ifdef RESULT_WRITER_PACK_EN
          state_nxt = pending ? WR_HI : WR_LO;
`else
          state_nxt = WR_LO;
`endif
        end else if (finish) begin
`ifdef RESULT_WRITER_PACK_EN
          state_nxt = pending ? WR_PART : WR_END;
`else
          state_nxt = WR_END;
`endif
        end
      end
      WR_LO: begin
        write      = 1'b1;
        byteenable = 2'b11;
        writedata  = hold[15:0];
`ifdef RESULT_WRITER_PACK_EN
        if (complete) begin
          count_step = 1'b1;
          if (limit_hit) begin
            state_nxt = tail ? DONE : WR_PART;
          end else begin
            state_nxt = FETCH;
          end
        end
`else
        if (complete) begin
          state_nxt = WR_HI;
        end
`endif
      end
      WR_HI: begin
        write = 1'b1;
`ifdef RESULT_WRITER_PACK_EN
        byteenable = 2'b11;
        writedata  = {hold_b[7:0], hold[23:16]};
        if (complete) begin
          state_nxt = WR_LO;
        end
`else
        byteenable = 2'b01;
        writedata  = {8'h00, hold[23:16]};
        if (complete) begin
          count_step = 1'b1;
          state_nxt  = limit_hit ? DONE : FETCH;
        end
`endif
      end
      WR_END: begin
        write      = 1'b1;
        byteenable = 2'b11;
        writedata  = END_MARKER;
        if (complete) begin
          state_nxt = DONE;
        end
      end
`ifdef RESULT_WRITER_PACK_EN
      WR_PART: begin
        write      = 1'b1;
        byteenable = 2'b11;
        writedata  = {8'h00, hold[23:16]};
        if (complete) begin
          state_nxt = marker_due ? WR_END : DONE;
        end
      end
`endif
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // run bookkeeping: pointer, limit, captured result, counters and flags
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr          <= '0;
      limit        <= '0;
      hold         <= '0;
      result_count <= '0;
      wrapped      <= 1'b0;
`ifdef RESULT_WRITER_PACK_EN
      hold_b       <= '0;
      pending      <= 1'b0;
      tail         <= 1'b0;
      marker_due   <= 1'b0;
`endif
    end else begin
      if (state == IDLE && start) begin
        ptr          <= base_address;
        limit        <= max_results;
        result_count <= '0;
        wrapped      <= 1'b0;
`ifdef RESULT_WRITER_PACK_EN
        pending      <= 1'b0;
        tail         <= 1'b0;
        marker_due   <= 1'b0;
`endif
      end else begin
        if (complete) begin
          ptr <= ptr + ADDR_WIDTH'(1);
          if (&ptr) begin
            wrapped <= 1'b1;
          end
        end
        if (count_step) begin
          result_count <= count_inc_val;
        end
      end
`ifdef RESULT_WRITER_PACK_EN
      if (rfifo_rdreq) begin
        if (pending) begin
          hold_b <= rfifo_dataq;
        end else begin
          hold <= rfifo_dataq;
        end
      end
      if (state == FETCH && rfifo_rdempty && finish && pending) begin
        marker_due <= 1'b1;
      end
      if (complete) begin
        case (state)
          WR_LO: begin
            if (tail) begin
              tail <= 1'b0;
            end else begin
              pending <= 1'b1;
            end
          end
          WR_HI: begin
            pending <= 1'b0;
            tail    <= 1'b1;
            hold    <= {8'h00, hold_b[23:8]};
          end
          WR_PART: begin
            pending <= 1'b0;
          end
          default: begin
          end
        endcase
      end
`else
      if (rfifo_rdreq) begin
        hold <= rfifo_dataq;
      end
`endif
    end
  end

endmodule
